// File: rtl/mips_avalon_arbiter.sv
// -----------------------------------------------------------------------------
// mips_avalon_arbiter
//
// Shares one Avalon-MM slave between the MIPS instruction-fetch master (read
// only) and the load/store master. One transaction is in flight at a time. The
// grant is held until the slave drops waitrequest. There is always one IDLE
// arbitration cycle between transactions. An optional stall watchdog
// force-completes a transaction that waits too long and sets a sticky error
// flag.
//
// Parameters
//   ARB_MODE  0 = fixed priority (data wins a tie)
//             1 = round-robin (the master not granted last wins a tie)
//   MAX_WAIT  stall-cycle limit (1..65535); 0 disables the watchdog
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   i_address/i_read               instruction master request
//   i_waitrequest/i_readdata       instruction master response
//   d_address/d_read/d_write/
//   d_writedata/d_byteenable       data master request
//   d_waitrequest/d_readdata       data master response
//   m_*                            shared slave port
//   grant                          {data, instr} one-hot grant, 00 when idle
//   timeout_err                    sticky watchdog flag
// -----------------------------------------------------------------------------
module mips_avalon_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam bit          WD_EN      = (MAX_WAIT != 0);
  localparam logic [15:0] MAX_WAIT_W = 16'(MAX_WAIT);

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_err_q, timeout_err_d;

  logic req_i, req_d;
  logic gnt_req;
  logic fire;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  // The granted master is still asking for the bus this cycle.
  assign gnt_req = ((state_q == GNT_I) && req_i) || ((state_q == GNT_D) && req_d);

  // Watchdog fires once the stall count has reached the limit; it takes
  // precedence over a slave completion in the same cycle.
  assign fire = WD_EN && gnt_req && (wait_cnt_q == MAX_WAIT_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_d_q      <= 1'b0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_d_q      <= last_d_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    last_d_d      = last_d_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (req_i && req_d) begin
          // Round-robin hands a tie to instr only if data had the last grant.
          if ((ARB_MODE != 0) && last_d_q) state_d = GNT_I;
          else                             state_d = GNT_D;
        end else if (req_d) begin
          state_d = GNT_D;
        end else if (req_i) begin
          state_d = GNT_I;
        end
      end

      GNT_I, GNT_D: begin
        if (!gnt_req) begin
          // Master withdrew its request: abandon without touching last_d.
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (fire) begin
          state_d       = IDLE;
          wait_cnt_d    = '0;
          timeout_err_d = 1'b1;
          last_d_d      = (state_q == GNT_D);
        end else if (!m_waitrequest) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
          last_d_d   = (state_q == GNT_D);
        end else if (WD_EN && (wait_cnt_q != MAX_WAIT_W)) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Output mux: idle drives nothing and stalls both masters.
  always_comb begin
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    m_address     = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_writedata   = '0;
    m_byteenable  = '0;
    grant         = 2'b00;

    unique case (state_q)
      GNT_I: begin
        grant         = 2'b01;
        m_address     = i_address;
        m_read        = i_read & ~fire;
        m_byteenable  = 4'b1111;
        i_waitrequest = fire ? 1'b0 : m_waitrequest;
      end
      GNT_D: begin
        grant         = 2'b10;
        m_address     = d_address;
        m_read        = d_read & ~fire;
        m_write       = d_write & ~fire;
        m_writedata   = d_writedata;
        m_byteenable  = d_byteenable;
        d_waitrequest = fire ? 1'b0 : m_waitrequest;
      end
      default: begin
      end
    endcase
  end

  // A forced completion returns zero rather than whatever the slave drives.
  assign i_readdata  = fire ? 32'd0 : m_readdata;
  assign d_readdata  = fire ? 32'd0 : m_readdata;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed bench for mips_avalon_arbiter. Three instances share one stimulus:
//   [0] fixed priority, no watchdog
//   [1] round-robin, no watchdog
//   [2] fixed priority, MAX_WAIT=4
// The bench plays the slave by driving m_waitrequest/m_readdata directly.
module tb_mips_avalon_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] i_address;
  logic        i_read;
  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;

  logic        i_wr   [3];
  logic [31:0] i_rd   [3];
  logic        d_wr   [3];
  logic [31:0] d_rd   [3];
  logic [31:0] m_addr [3];
  logic        m_rd   [3];
  logic        m_wr   [3];
  logic [31:0] m_wd   [3];
  logic [3:0]  m_be   [3];
  logic [1:0]  gnt    [3];
  logic        to_err [3];

  logic [31:0] slave_word;
  logic [1:0]  rr_exp [4];

  int checks;
  int errors;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mips_avalon_arbiter #(
      .ARB_MODE(g == 1 ? 1 : 0),
      .MAX_WAIT(g == 2 ? 4 : 0)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .i_address     (i_address),
      .i_read        (i_read),
      .i_waitrequest (i_wr[g]),
      .i_readdata    (i_rd[g]),
      .d_address     (d_address),
      .d_read        (d_read),
      .d_write       (d_write),
      .d_writedata   (d_writedata),
      .d_byteenable  (d_byteenable),
      .d_waitrequest (d_wr[g]),
      .d_readdata    (d_rd[g]),
      .m_address     (m_addr[g]),
      .m_read        (m_rd[g]),
      .m_write       (m_wr[g]),
      .m_writedata   (m_wd[g]),
      .m_byteenable  (m_be[g]),
      .m_waitrequest (m_waitrequest),
      .m_readdata    (m_readdata),
      .grant         (gnt[g]),
      .timeout_err   (to_err[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave storage for the one word written through instance 0.
  always @(posedge clk) begin
    if (rst) begin
      slave_word <= 32'h12345678;
    end else if (m_wr[0] && !m_waitrequest && (m_addr[0] == 32'hBFC00004)) begin
      if (m_be[0][0]) slave_word[7:0]   <= m_wd[0][7:0];
      if (m_be[0][1]) slave_word[15:8]  <= m_wd[0][15:8];
      if (m_be[0][2]) slave_word[23:16] <= m_wd[0][23:16];
      if (m_be[0][3]) slave_word[31:24] <= m_wd[0][31:24];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rr_exp        = '{2'b10, 2'b01, 2'b10, 2'b01};
    rst           = 1'b0;
    i_address     = '0;
    i_read        = 1'b0;
    d_address     = '0;
    d_read        = 1'b0;
    d_write       = 1'b0;
    d_writedata   = '0;
    d_byteenable  = '0;
    m_waitrequest = 1'b1;
    m_readdata    = '0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_grant",  32'(gnt[0]), 32'h0);
    chk("rst_iwait",  32'(i_wr[0]), 32'h1);
    chk("rst_dwait",  32'(d_wr[0]), 32'h1);
    chk("rst_mread",  32'(m_rd[0]), 32'h0);
    chk("rst_timeout", 32'(to_err[2]), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Instruction read alone, slave takes two wait cycles
    i_address = 32'hBFC00000;
    i_read    = 1'b1;
    #1;
    chk("t1_idle_grant", 32'(gnt[0]), 32'h0);
    chk("t1_idle_mread", 32'(m_rd[0]), 32'h0);
    tick();
    chk("t1_grant",  32'(gnt[0]), 32'h1);
    chk("t1_mread",  32'(m_rd[0]), 32'h1);
    chk("t1_maddr",  m_addr[0], 32'hBFC00000);
    chk("t1_mbe",    32'(m_be[0]), 32'hF);
    chk("t1_iwait",  32'(i_wr[0]), 32'h1);
    chk("t1_dwait",  32'(d_wr[0]), 32'h1);
    tick();
    m_waitrequest = 1'b0;
    m_readdata    = 32'h2402000A;
    #1;
    chk("t1_iwait_low", 32'(i_wr[0]), 32'h0);
    chk("t1_irdata",    i_rd[0], 32'h2402000A);
    tick();
    chk("t1_after_grant", 32'(gnt[0]), 32'h0);
    chk("t1_after_iwait", 32'(i_wr[0]), 32'h1);
    i_read        = 1'b0;
    m_waitrequest = 1'b1;
    m_readdata    = '0;

    // Simultaneous instr read and data write, fixed priority
    i_read       = 1'b1;
    d_write      = 1'b1;
    d_address    = 32'hBFC00004;
    d_writedata  = 32'hAABBCCDD;
    d_byteenable = 4'b0011;
    tick();
    chk("t2_grant",  32'(gnt[0]), 32'h2);
    chk("t2_mwrite", 32'(m_wr[0]), 32'h1);
    chk("t2_mread",  32'(m_rd[0]), 32'h0);
    chk("t2_mbe",    32'(m_be[0]), 32'h3);
    chk("t2_maddr",  m_addr[0], 32'hBFC00004);
    chk("t2_mwdata", m_wd[0], 32'hAABBCCDD);
    chk("t2_iwait",  32'(i_wr[0]), 32'h1);
    m_waitrequest = 1'b0;
    #1;
    chk("t2_dwait_low", 32'(d_wr[0]), 32'h0);
    chk("t2_iwait_hi",  32'(i_wr[0]), 32'h1);
    tick();
    chk("t2_slave_word", slave_word, 32'h1234CCDD);
    chk("t2_idle_grant", 32'(gnt[0]), 32'h0);
    chk("t2_idle_iwait", 32'(i_wr[0]), 32'h1);
    d_write       = 1'b0;
    d_byteenable  = '0;
    m_waitrequest = 1'b1;
    tick();
    chk("t2_igrant", 32'(gnt[0]), 32'h1);
    chk("t2_i_mwrite", 32'(m_wr[0]), 32'h0);
    chk("t2_i_mbe",  32'(m_be[0]), 32'hF);
    m_waitrequest = 1'b0;
    tick();
    i_read = 1'b0;

    // Continuous contention: round-robin alternates, fixed priority starves instr
    i_read    = 1'b1;
    d_read    = 1'b1;
    i_address = 32'hBFC00008;
    d_address = 32'h00000200;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t3_fp_grant%0d", k), 32'(gnt[0]), 32'h2);
      chk($sformatf("t3_rr_grant%0d", k), 32'(gnt[1]), 32'(rr_exp[k]));
      tick();
      chk($sformatf("t3_rr_idle%0d", k), 32'(gnt[1]), 32'h0);
    end
    i_read = 1'b0;
    d_read = 1'b0;

    // Watchdog: slave stalls forever
    d_read        = 1'b1;
    d_address     = 32'h00000100;
    m_waitrequest = 1'b1;
    m_readdata    = 32'hDEADBEEF;
    tick();
    chk("t4_grant", 32'(gnt[2]), 32'h2);
    chk("t4_dwait0", 32'(d_wr[2]), 32'h1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("t4_dwait%0d", k), 32'(d_wr[2]), 32'h1);
      chk($sformatf("t4_mread%0d", k), 32'(m_rd[2]), 32'h1);
    end
    tick();
    chk("t4_fire_dwait", 32'(d_wr[2]), 32'h0);
    chk("t4_fire_rdata", d_rd[2], 32'h0);
    chk("t4_fire_mread", 32'(m_rd[2]), 32'h0);
    chk("t4_fire_grant", 32'(gnt[2]), 32'h2);
    chk("t4_fire_to",    32'(to_err[2]), 32'h0);
    chk("t4_nowd_rdata", d_rd[0], 32'hDEADBEEF);
    chk("t4_nowd_dwait", 32'(d_wr[0]), 32'h1);
    tick();
    chk("t4_idle_grant", 32'(gnt[2]), 32'h0);
    chk("t4_to_set",     32'(to_err[2]), 32'h1);
    d_read     = 1'b0;
    m_readdata = '0;
    tick();
    tick();
    chk("t4_to_sticky", 32'(to_err[2]), 32'h1);

    // Asynchronous reset in the middle of a data grant
    d_write       = 1'b1;
    d_address     = 32'h00000300;
    d_writedata   = 32'h00000055;
    d_byteenable  = 4'hF;
    m_waitrequest = 1'b1;
    tick();
    chk("t5_mwrite", 32'(m_wr[0]), 32'h1);
    chk("t5_grant",  32'(gnt[0]), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_mwrite", 32'(m_wr[0]), 32'h0);
    chk("t5_rst_grant",  32'(gnt[0]), 32'h0);
    chk("t5_rst_dwait",  32'(d_wr[0]), 32'h1);
    chk("t5_rst_to",     32'(to_err[2]), 32'h0);
    d_write = 1'b0;
    tick();
    rst = 1'b0;
    chk("t5_rel_grant", 32'(gnt[0]), 32'h0);
    tick();
    chk("t5_idle_grant", 32'(gnt[0]), 32'h0);
    i_read    = 1'b1;
    i_address = 32'hBFC00000;
    tick();
    chk("t5_igrant", 32'(gnt[0]), 32'h1);
    m_waitrequest = 1'b0;
    tick();
    i_read        = 1'b0;
    m_waitrequest = 1'b1;

    // Data master abandons its grant; last_d must not change
    d_read    = 1'b1;
    d_address = 32'h00000400;
    i_read    = 1'b1;
    i_address = 32'hBFC00010;
    tick();
    chk("t6_rr_dgrant", 32'(gnt[1]), 32'h2);
    chk("t6_fp_dgrant", 32'(gnt[0]), 32'h2);
    chk("t6_iwait",     32'(i_wr[1]), 32'h1);
    d_read = 1'b0;
    tick();
    chk("t6_abandon_idle", 32'(gnt[1]), 32'h0);
    tick();
    chk("t6_rr_igrant", 32'(gnt[1]), 32'h1);
    chk("t6_fp_igrant", 32'(gnt[0]), 32'h1);
    i_read = 1'b0;
    tick();
    chk("t6_iabandon_idle", 32'(gnt[1]), 32'h0);
    i_read = 1'b1;
    d_read = 1'b1;
    tick();
    chk("t6_rr_lastd_kept", 32'(gnt[1]), 32'h2);
    i_read = 1'b0;
    d_read = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_avalon_arbiter.md
Name: mips_avalon_arbiter

Overview:
Two-master to one-slave Avalon-MM arbiter that shares a single memory slave (e.g. mips_avalon_slave) between the CPU instruction-fetch port and its load/store port. It sequences one transaction at a time and holds the grant until the slave completes, i.e. drops waitrequest. It adds a per-transaction stall watchdog. It sits between the MIPS core's two bus ports and the memory/peripheral slave.

Parameters:
- ARB_MODE, 0: tie-break rule. 0 = fixed priority, data wins. 1 = round-robin, the master not granted last wins.
- MAX_WAIT, 0: stall watchdog limit in cycles, range 1..65535. 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- i_address  in  32  instruction master address
- i_read  in  1  instruction master read request
- i_waitrequest  out  1  stall to instruction master
- i_readdata  out  32  read data to instruction master
- d_address  in  32  data master address
- d_read  in  1  data master read request
- d_write  in  1  data master write request
- d_writedata  in  32  data master write data
- d_byteenable  in  4  data master byte enables
- d_waitrequest  out  1  stall to data master
- d_readdata  out  32  read data to data master
- m_address  out  32  address to slave
- m_read  out  1  read to slave
- m_write  out  1  write to slave
- m_writedata  out  32  write data to slave
- m_byteenable  out  4  byte enables to slave; 4'b1111 for instruction reads
- m_waitrequest  in  1  slave stall
- m_readdata  in  32  slave read data
- grant  out  2  {data, instr} one-hot current grant; 2'b00 when idle
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- States: IDLE, GNT_I, GNT_D. last_d is a 1-bit register recording the last granted master. wait_cnt is a 16-bit counter.
- Reset (async, rst=1): state IDLE, last_d=0, wait_cnt=0, timeout_err=0. Outputs follow IDLE values immediately, not at the next edge.
- Request definitions: req_i = i_read. req_d = d_read | d_write.
- IDLE transitions:
  - No request: stay in IDLE.
  - Only one request: go to that master's grant state.
  - Both requesting: ARB_MODE=0 goes to GNT_D. ARB_MODE=1 goes to GNT_I if last_d=1, otherwise GNT_D.
  - Arbitration costs one cycle: in IDLE both master waitrequests are 1 and m_read, m_write, m_address, m_writedata, m_byteenable are all 0.
- GNT_x: the granted master's signals drive m_* combinationally. Its waitrequest equals m_waitrequest. The other master sees waitrequest=1.
- Completion: in GNT_x, a clock edge with req_x=1 and m_waitrequest=0.
  - Next state IDLE. last_d updated (1 if GNT_D). wait_cnt cleared.
  - There is always one IDLE cycle between transactions; there is no back-to-back grant.
- Abandon: in GNT_x with req_x=0, go to IDLE at the next edge and clear wait_cnt. last_d is not updated.
- Watchdog (MAX_WAIT != 0):
  - wait_cnt increments on each GNT_x cycle with req_x=1 and m_waitrequest=1. It saturates at MAX_WAIT.
  - fire = GNT_x & req_x & (wait_cnt == MAX_WAIT).
  - In a fire cycle: m_read=m_write=0, the granted master's waitrequest=0, and its readdata=0.
  - At the next edge: state IDLE, timeout_err=1 (cleared only by reset), last_d updated.
  - If the slave completes on the same cycle fire would assert, fire wins.
- Read data: i_readdata and d_readdata both equal m_readdata, except 0 in a fire cycle.
- A write from the instruction master is impossible by construction: m_write is driven only in GNT_D.
- Address and data are passed unmodified. There is no address decode.

Test Plan:
- Instr read alone (slave READ_DELAY=2, mem[0]=0x2402000A), i_read at 0xBFC00000 → grant=01 one cycle after request; i_waitrequest falls with slave; i_readdata=0x2402000A; then one IDLE cycle with grant=00.
- ARB_MODE=0, i_read and d_write (0xBFC00004, data 0xAABBCCDD, be 4'b0011) in the same cycle → GNT_D first; m_byteenable=0011; slave word low half = 0xCCDD; then GNT_I; i_waitrequest=1 throughout the data transaction.
- ARB_MODE=1, both masters request continuously for 4 transactions → grant order D, I, D, I. ARB_MODE=0 under the same stimulus → D, D, D, D (instr starved).
- MAX_WAIT=4, slave holds m_waitrequest=1 → 4 stall cycles, then a fire cycle with d_waitrequest=0, d_readdata=0, m_read=0; timeout_err=1 and remains 1 until rst.
- rst asserted mid-GNT_D (between clock edges) → m_write and grant drop to 0 before the next edge; after release the FSM is in IDLE and timeout_err=0.
- Data master drops d_read while in GNT_D → IDLE next cycle; a pending i_read is granted after that, with last_d unchanged.
